mbgate_rr_sched: RTL and testbench

- Round-robin scheduler that shares one multi-bit bitwise gate unit between NREQ requesters.
- Supported operations: AND, OR, XOR, NOT, NAND, NOR, XNOR.
- Each requester presents an opcode and two operands on a valid/ready handshake. The scheduler grants one requester per cycle, evaluates the operation, and returns the result with the winner's ID through a single-entry registered output buffer.
- Sits between the gate-level datapath blocks and any upstream masters that need bitwise ops without owning a dedicated gate bank.

---
 rtl/mbgate_rr_sched.sv | 161 ++++++++++++++++
 tb/tb_mbgate_rr_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbgate_rr_sched.sv
// mbgate_rr_sched: round-robin scheduler that shares one bitwise gate unit
// between NREQ requesters. The winner's result lands in a single-entry
// registered output buffer that carries the requester ID and an error flag.
module mbgate_rr_sched #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [3*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_a,
  input  logic [WIDTH*NREQ-1:0]    req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [IDW-1:0]           res_id,
  output logic                     res_err,
  output logic [7:0]               busy_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               err_q, err_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [7:0]         busy_q, busy_d;

  logic               can_accept;
  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  logic [2*NREQ-1:0]  dbl_valid;
  logic [NREQ-1:0]    rot_valid;
  logic [IDW:0]       idx_sum;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Bitwise gate evaluation; opcode 7 is illegal and yields zero.
  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~a;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // A new result may be written when the buffer is empty or being drained.
  assign can_accept = (state_q == EMPTY) | res_ready;

  // Rotated priority search starting at ptr: rot_valid[k] is requester (ptr+k) mod NREQ.
  always_comb begin
    dbl_valid = {req_valid, req_valid};
    rot_valid = NREQ'(dbl_valid >> ptr_q);
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (can_accept && rot_valid[k]) begin
        idx_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
        if (idx_sum >= (IDW + 1)'(NREQ)) begin
          idx_sum = idx_sum - (IDW + 1)'(NREQ);
        end
        grant_vld = 1'b1;
        grant_idx = idx_sum[IDW-1:0];
      end
    end
  end

  // One-hot ready to the winner and operand mux for the shared gate unit.
  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        sel_op       = req_op[3*i +: 3];
        sel_a        = req_a[WIDTH*i +: WIDTH];
        sel_b        = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer next state: a grant fills it, a drain without refill empties it.
  always_comb begin
    state_d = state_q;
    if (grant_vld) begin
      state_d = FULL;
    end else if (res_ready) begin
      state_d = EMPTY;
    end
  end

  // Buffer outputs driven from the registered state.
  always_comb begin
    res_valid = (state_q == FULL);
    res_data  = data_q;
    res_id    = id_q;
    res_err   = err_q;
    busy_cnt  = busy_q;
  end

  // Result payload, round-robin pointer and stall counter updates.
  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    err_d  = err_q;
    ptr_d  = ptr_q;
    busy_d = busy_q;
    if (grant_vld) begin
      data_d = gate_eval(sel_op, sel_a, sel_b);
      id_d   = grant_idx;
      err_d  = (sel_op == 3'd7);
      ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (|req_valid && (busy_q != 8'hFF)) begin
      busy_d = busy_q + 8'd1;
    end
  end

  // Payload and control registers; reset discards any result in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
      ptr_q  <= '0;
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
      err_q  <= err_d;
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_mbgate_rr_sched.sv
// Testbench for mbgate_rr_sched: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of the scheduler.
module tb_mbgate_rr_sched;

  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_err;
  logic [7:0]            busy_cnt;

  mbgate_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_err(res_err),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the output buffer should hold.
  int m_ptr;
  int m_valid;
  int m_data;
  int m_id;
  int m_err;
  int m_busy;
  int last_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_gate(input int op, input int a, input int b);
    int mask;
    mask = (1 << WIDTH) - 1;
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return mask - a;
      4: return mask - (a & b);
      5: return mask - (a | b);
      6: return mask - (a ^ b);
      default: return 0;
    endcase
  endfunction

  function automatic int ref_grant();
    int idx;
    if (m_valid != 0 && !res_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic set_req(input int i, input int op, input int a, input int b);
    req_valid[i] = 1'b1;
    req_op[3*i +: 3] = 3'(op);
    req_a[WIDTH*i +: WIDTH] = WIDTH'(a);
    req_b[WIDTH*i +: WIDTH] = WIDTH'(b);
  endtask

  // Compare every DUT output with the model, away from the rising edge.
  task automatic at_neg();
    int g;
    @(negedge clk);
    g = ref_grant();
    chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_data", 32'(res_data), 32'(m_data));
    chk("res_id", 32'(res_id), 32'(m_id));
    chk("res_err", 32'(res_err), 32'(m_err));
    chk("busy_cnt", 32'(busy_cnt), 32'(m_busy));
  endtask

  // Advance one clock and apply the transfer rules to the model.
  task automatic adv();
    int g, op, a, b, any;
    g = ref_grant();
    any = (req_valid != 0) ? 1 : 0;
    op = 0; a = 0; b = 0;
    if (g >= 0) begin
      op = int'(req_op[3*g +: 3]);
      a  = int'(req_a[WIDTH*g +: WIDTH]);
      b  = int'(req_b[WIDTH*g +: WIDTH]);
    end
    @(posedge clk);
    if (!rst) begin
      if (g >= 0) begin
        m_data  = ref_gate(op, a, b);
        m_id    = g;
        m_err   = (op == 7) ? 1 : 0;
        m_valid = 1;
        m_ptr   = (g + 1) % NREQ;
      end else begin
        if (res_ready) m_valid = 0;
        if (any != 0 && m_busy < 255) m_busy++;
      end
    end
    #1;
    last_grant = g;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int ord [5]    = '{0, 1, 2, 3, 0};
  int expres [5] = '{7, 1, 1, 6, 7};
  int b0;

  initial begin
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    res_ready = 1'b1;
    rst = 1'b1;
    last_grant = -1;
    model_reset();
    @(posedge clk); #1;
    at_neg();
    chk("rst_busy", 32'(busy_cnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single requester AND.
    set_req(0, 0, 3'b110, 3'b011);
    at_neg();
    chk("t1_ready", 32'(req_ready), 32'b0001);
    adv();
    req_valid = '0;
    at_neg();
    chk("t1_data", 32'(res_data), 32'b010);
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_id", 32'(res_id), 32'd0);
    adv();

    // All four requesters persistent: strict rotation without bubbles.
    pulse_reset();
    set_req(0, 1, 6, 7); set_req(1, 2, 6, 7); set_req(2, 4, 6, 7); set_req(3, 6, 6, 7);
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("t2_grant", 32'(req_ready), 32'd1 << ord[k]);
      if (k > 0) begin
        chk("t2_data", 32'(res_data), 32'(expres[k-1]));
        chk("t2_valid", 32'(res_valid), 32'd1);
      end
      adv();
    end

    // Backpressure with requester 1 waiting.
    req_valid = '0;
    set_req(1, 0, 5, 3);
    res_ready = 1'b0;
    b0 = m_busy;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("t3_ready", 32'(req_ready), 32'd0);
      chk("t3_data", 32'(res_data), 32'(expres[4]));
      chk("t3_id", 32'(res_id), 32'd0);
      adv();
    end
    at_neg();
    chk("t3_busy", 32'(busy_cnt), 32'(b0 + 5));
    res_ready = 1'b1;
    #1 chk("t3_release", 32'(req_ready), 32'b0010);
    adv();
    req_valid = '0;

    // Opcode edge cases on requester 2.
    set_req(2, 3, 2, $urandom_range(0, 7));
    at_neg();
    adv();
    req_valid = '0;
    at_neg();
    chk("t4_not", 32'(res_data), 32'd5);
    chk("t4_not_err", 32'(res_err), 32'd0);
    set_req(2, 7, $urandom_range(0, 7), $urandom_range(0, 7));
    adv();
    req_valid = '0;
    at_neg();
    chk("t4_ill_data", 32'(res_data), 32'd0);
    chk("t4_ill_err", 32'(res_err), 32'd1);
    chk("t4_ill_id", 32'(res_id), 32'd2);

    // Wrap: pointer sits at 3 with requesters 0 and 3 pending.
    set_req(0, 0, 7, 7); set_req(3, 1, 1, 2);
    #1 chk("t5_first", 32'(req_ready), 32'b1000);
    adv();
    req_valid[3] = 1'b0;
    at_neg();
    chk("t5_second", 32'(req_ready), 32'b0001);
    adv();
    set_req(0, 0, 1, 1); set_req(1, 1, 1, 1); set_req(2, 2, 1, 1); set_req(3, 5, 1, 1);
    at_neg();
    chk("t5_ptr1", 32'(req_ready), 32'b0010);
    adv();

    // Asynchronous reset while full with requests pending.
    req_valid = 4'b1100;
    res_ready = 1'b0;
    at_neg();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_valid", 32'(res_valid), 32'd0);
    chk("t6_data", 32'(res_data), 32'd0);
    chk("t6_busy", 32'(busy_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    at_neg();
    chk("t6_first", 32'(req_ready), 32'b0100);
    adv();

    // Randomized traffic obeying the hold-until-ready rule.
    req_valid = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant == i || !req_valid[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 1) == 1)
            set_req(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      at_neg();
      adv();
    end

    // Stall counter saturation.
    req_valid = 4'b0001;
    res_ready = 1'b0;
    for (int n = 0; n < 300; n++) begin
      at_neg();
      adv();
    end
    at_neg();
    chk("sat_busy", 32'(busy_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
